memory_bridge: RTL and testbench



---
 rtl/memory_bridge.sv | 119 +++++++++++
 tb/tb_memory_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/memory_bridge.sv
// rtl/memory_bridge.sv - core strobe to req/ack memory bus bridge with per-transaction timeout
// Every output is driven from a register; the FSM owns all state in one sequential block.
module memory_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  memory_response,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_fault
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    HOLD
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    resp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    req_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    fault_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (memory_write) begin
            addr_q  <= address;
            wdata_q <= write_data;
            we_q    <= 1'b1;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (memory_read) begin
            addr_q  <= address;
            we_q    <= 1'b0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // An ack in the timeout cycle still counts as a clean completion.
          if (bus_ack) begin
            if (!we_q) rdata_q <= bus_rdata;
            req_q   <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            fault_q <= 1'b1;
            if (!we_q) rdata_q <= '0;
            req_q   <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          // Swallows the strobe the control unit keeps up one cycle past the response.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign memory_response = resp_q;
  assign read_data       = rdata_q;
  assign bus_req         = req_q;
  assign bus_we          = we_q;
  assign bus_addr        = addr_q;
  assign bus_wdata       = wdata_q;
  assign bus_fault       = fault_q;

endmodule

// File: tb/tb_memory_bridge.sv
// tb/tb_memory_bridge.sv - directed self-checking bench for memory_bridge
module tb_memory_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, ack;
  logic [31:0] addr, wdata, rdata;
  logic        resp, req, we, fault;
  logic [31:0] rdout, baddr, bwdata;
  logic        w_rd, w_wr, w_ack;
  logic        w_resp, w_req, w_we, w_fault;
  logic [31:0] w_rdout, w_baddr, w_bwdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  memory_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memory_read(rd), .memory_write(wr),
    .address(addr), .write_data(wdata), .memory_response(resp), .read_data(rdout),
    .bus_req(req), .bus_we(we), .bus_addr(baddr), .bus_wdata(bwdata),
    .bus_ack(ack), .bus_rdata(rdata), .bus_fault(fault)
  );

  // Longer timeout so a five-cycle wait state completes without faulting.
  memory_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut_w (
    .clk(clk), .reset(reset), .memory_read(w_rd), .memory_write(w_wr),
    .address(addr), .write_data(wdata), .memory_response(w_resp), .read_data(w_rdout),
    .bus_req(w_req), .bus_we(w_we), .bus_addr(w_baddr), .bus_wdata(w_bwdata),
    .bus_ack(w_ack), .bus_rdata(rdata), .bus_fault(w_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rd = 0; wr = 0; ack = 0; addr = 0; wdata = 0; rdata = 0;
    w_rd = 0; w_wr = 0; w_ack = 0;
    tick(); tick();
    check("rst_resp", resp, 0);   check("rst_rdata", rdout, 0);
    check("rst_req", req, 0);     check("rst_we", we, 0);
    check("rst_addr", baddr, 0);  check("rst_wdata", bwdata, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;
    tick();

    // zero-wait read, single-cycle strobe; ack held early must be ignored in IDLE
    rd = 1; addr = 32'h10; ack = 1; rdata = 32'hDEAD_BEEF;
    tick();
    check("zw_req", req, 1); check("zw_we", we, 0); check("zw_addr", baddr, 32'h10);
    check("zw_resp_early", resp, 0);
    rd = 0;
    tick();
    check("zw_req_drop", req, 0); check("zw_resp", resp, 1);
    check("zw_rdata", rdout, 32'hDEAD_BEEF);
    ack = 0;
    tick();
    check("zw_resp_pulse", resp, 0);
    tick();
    check("zw_rdata_held", rdout, 32'hDEAD_BEEF); check("zw_idle_req", req, 0);

    // fetch with strobe held through response and the HOLD cycle
    rd = 1; addr = 32'h20; rdata = 32'h1111_2222;
    tick();
    check("fh_req", req, 1);
    ack = 1;
    tick();
    check("fh_resp", resp, 1); check("fh_rdata", rdout, 32'h1111_2222);
    ack = 0;
    tick();
    check("fh_hold_req", req, 0); check("fh_hold_resp", resp, 0);
    rd = 0;
    tick();
    check("fh_no_dup", req, 0);
    tick();
    check("fh_no_dup2", req, 0);

    // simultaneous strobes: write wins, read_data untouched
    rd = 1; wr = 1; addr = 32'h70; wdata = 32'hA5A5_A5A5; ack = 1; rdata = 32'hFFFF_FFFF;
    tick();
    check("sim_req", req, 1); check("sim_we", we, 1);
    check("sim_addr", baddr, 32'h70); check("sim_wdata", bwdata, 32'hA5A5_A5A5);
    rd = 0; wr = 0;
    tick();
    check("sim_resp", resp, 1); check("sim_rdata", rdout, 32'h1111_2222);
    ack = 0;
    tick(); tick();

    // waited write on the long-timeout instance, preceded by a read to seed read_data
    w_rd = 1; addr = 32'h40; rdata = 32'hCAFE_F00D; w_ack = 1;
    tick();
    w_rd = 0;
    tick();
    check("ww_seed_rdata", w_rdout, 32'hCAFE_F00D);
    w_ack = 0;
    tick(); tick();
    w_wr = 1; addr = 32'h100; wdata = 32'h1234_5678; rdata = 32'hBADB_AD00;
    tick();
    w_wr = 0; addr = 32'hFFFF_0000; wdata = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("ww_req_%0d", i), w_req, 1);
      check($sformatf("ww_we_%0d", i), w_we, 1);
      check($sformatf("ww_wdata_%0d", i), w_bwdata, 32'h1234_5678);
      check($sformatf("ww_addr_%0d", i), w_baddr, 32'h100);
      check($sformatf("ww_noresp_%0d", i), w_resp, 0);
      if (i == 5) w_ack = 1;
      tick();
    end
    check("ww_resp", w_resp, 1); check("ww_req_drop", w_req, 0);
    check("ww_rdata_kept", w_rdout, 32'hCAFE_F00D); check("ww_fault", w_fault, 0);
    w_ack = 0;
    tick();
    check("ww_resp_pulse", w_resp, 0);
    tick();

    // read timeout with TIMEOUT_CYCLES=4
    rd = 1; addr = 32'h30;
    tick();
    rd = 0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req_%0d", i), req, 1);
      check($sformatf("to_noresp_%0d", i), resp, 0);
      tick();
    end
    check("to_req_drop", req, 0); check("to_resp", resp, 1);
    check("to_fault", fault, 1); check("to_rdata", rdout, 0);
    tick();
    check("to_resp_pulse", resp, 0);
    tick();

    // faulted write still responds; read_data stays zero
    wr = 1; addr = 32'h34; wdata = 32'h7777_7777;
    tick();
    wr = 0;
    tick(); tick(); tick(); tick();
    check("tw_resp", resp, 1); check("tw_fault", fault, 1); check("tw_rdata", rdout, 0);
    tick(); tick();

    // good read afterwards: fault stays sticky
    rd = 1; addr = 32'h50; ack = 1; rdata = 32'h55AA_55AA;
    tick();
    rd = 0;
    tick();
    check("gr_resp", resp, 1); check("gr_rdata", rdout, 32'h55AA_55AA);
    check("gr_fault_sticky", fault, 1);
    ack = 0;
    tick(); tick();

    // asynchronous reset mid-REQ
    rd = 1; addr = 32'h60;
    tick();
    check("rr_req", req, 1);
    rd = 0;
    #2 reset = 1'b1;
    #1;
    check("rr_req_async", req, 0); check("rr_fault_async", fault, 0);
    check("rr_rdata_async", rdout, 0); check("rr_addr_async", baddr, 0);
    check("rr_resp_async", resp, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rr_no_resp", resp, 0); check("rr_idle_req", req, 0);

    // ack exactly on the 4th REQ cycle, strobe held for back-to-back
    rd = 1; addr = 32'h80; rdata = 32'h0BAD_CAFE;
    tick();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("a4_req_%0d", i), req, 1);
      if (i == 4) ack = 1;
      tick();
    end
    check("a4_resp", resp, 1); check("a4_fault", fault, 0);
    check("a4_rdata", rdout, 32'h0BAD_CAFE);
    ack = 0;
    tick();
    check("a4_hold_req", req, 0);
    tick();
    check("a4_idle_req", req, 0);
    tick();
    check("b2b_req", req, 1); check("b2b_addr", baddr, 32'h80);
    rd = 0; ack = 1; rdata = 32'h0000_0042;
    tick();
    check("b2b_resp", resp, 1); check("b2b_rdata", rdout, 32'h0000_0042);
    ack = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
